// File: rtl/matmul_ctrl.sv
// matmul_ctrl: job sequencer and X/Y/Z BRAM port owner for the matmul engine.
// Optional RUN watchdog enabled by defining MATMUL_CTRL_TIMEOUT_EN.
//
// state | meaning
// IDLE  | host owns ports, cmd_ready high
// GRANT | ports handed to engine
// START | eng_start pulse
// RUN   | wait for eng_done rising edge (or watchdog)
// DRAIN | engine keeps ports so its last Z write lands
// DONE  | ports back to host, done_pulse
module matmul_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned MATRIX_SIZE    = 32,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic                  busy,
  output logic                  done_pulse,
  output logic                  timeout,
  output logic [31:0]           run_cycles,
  output logic                  host_wr_err,
  input  logic [ADDR_WIDTH-1:0] host_x_addr,
  input  logic [ADDR_WIDTH-1:0] host_y_addr,
  input  logic [ADDR_WIDTH-1:0] host_z_addr,
  input  logic [DATA_WIDTH-1:0] host_x_din,
  input  logic [DATA_WIDTH-1:0] host_y_din,
  input  logic                  host_x_wr_en,
  input  logic                  host_y_wr_en,
  output logic                  eng_start,
  input  logic                  eng_done,
  input  logic [ADDR_WIDTH-1:0] eng_x_addr,
  input  logic [ADDR_WIDTH-1:0] eng_y_addr,
  input  logic [ADDR_WIDTH-1:0] eng_z_addr,
  input  logic [DATA_WIDTH-1:0] eng_z_din,
  input  logic                  eng_z_wr_en,
  output logic [ADDR_WIDTH-1:0] x_addr,
  output logic [ADDR_WIDTH-1:0] y_addr,
  output logic [ADDR_WIDTH-1:0] z_addr,
  output logic [DATA_WIDTH-1:0] x_din,
  output logic [DATA_WIDTH-1:0] y_din,
  output logic [DATA_WIDTH-1:0] z_din,
  output logic                  x_wr_en,
  output logic                  y_wr_en,
  output logic                  z_wr_en
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam logic OWN_HOST   = 1'b0;
  localparam logic OWN_ENGINE = 1'b1;

`ifdef MATMUL_CTRL_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);
`endif

  // Elaboration-time sanity on the geometry handed to the engine.
  if (64'(MATRIX_SIZE) * 64'(MATRIX_SIZE) > (64'd1 << ADDR_WIDTH)) begin : g_size_chk
    $error("matmul_ctrl: MATRIX_SIZE*MATRIX_SIZE exceeds 2**ADDR_WIDTH");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_chk
    $error("matmul_ctrl: TIMEOUT_CYCLES must be nonzero");
  end

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        done_q, done_d;
  logic [31:0] run_cycles_q, run_cycles_d;
  logic        timeout_q, timeout_d;
  logic        host_wr_err_q, host_wr_err_d;
  logic [31:0] run_inc;
  logic        done_rise;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      owner_q       <= OWN_HOST;
      done_q        <= 1'b0;
      run_cycles_q  <= '0;
      timeout_q     <= 1'b0;
      host_wr_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      done_q        <= done_d;
      run_cycles_q  <= run_cycles_d;
      timeout_q     <= timeout_d;
      host_wr_err_q <= host_wr_err_d;
    end
  end

  // Only a fresh rise counts; a level left high by the previous job is ignored.
  assign done_rise = eng_done & ~done_q;

  always_comb begin
    state_d       = state_q;
    run_cycles_d  = run_cycles_q;
    timeout_d     = timeout_q;
    done_d        = eng_done;
    host_wr_err_d = (owner_q == OWN_ENGINE) & (host_x_wr_en | host_y_wr_en);
    run_inc       = (&run_cycles_q) ? run_cycles_q : run_cycles_q + 32'd1;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d      = S_GRANT;
          run_cycles_d = '0;
          timeout_d    = 1'b0;
        end
      end
      S_GRANT: state_d = S_START;
      S_START: state_d = S_RUN;
      S_RUN: begin
        run_cycles_d = run_inc;
        if (done_rise) begin
          state_d = S_DRAIN;
`ifdef MATMUL_CTRL_TIMEOUT_EN
        end else if (run_inc >= TIMEOUT_LIM) begin
          state_d   = S_DRAIN;
          timeout_d = 1'b1;
`endif
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    owner_d = (state_d == S_GRANT || state_d == S_START ||
               state_d == S_RUN   || state_d == S_DRAIN) ? OWN_ENGINE : OWN_HOST;
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign eng_start   = (state_q == S_START);
  assign done_pulse  = (state_q == S_DONE);
  assign run_cycles  = run_cycles_q;
  assign timeout     = timeout_q;
  assign host_wr_err = host_wr_err_q;

  always_comb begin
    x_din = host_x_din;
    y_din = host_y_din;
    z_din = eng_z_din;
    if (owner_q == OWN_ENGINE) begin
      x_addr  = eng_x_addr;
      y_addr  = eng_y_addr;
      z_addr  = eng_z_addr;
      x_wr_en = 1'b0;
      y_wr_en = 1'b0;
      z_wr_en = eng_z_wr_en;
    end else begin
      x_addr  = host_x_addr;
      y_addr  = host_y_addr;
      z_addr  = host_z_addr;
      x_wr_en = host_x_wr_en;
      y_wr_en = host_y_wr_en;
      z_wr_en = 1'b0;
    end
  end

endmodule

// File: tb/tb_matmul_ctrl.sv
// Self-checking bench for matmul_ctrl: BRAM and engine behavioural models,
// randomized matrices checked against a plain matrix-product reference.
module tb_matmul_ctrl;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int N  = 4;
  localparam int NN = N * N;
  localparam int TO = 50;

  logic          clock = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, busy, done_pulse, timeout, host_wr_err;
  logic [31:0]   run_cycles;
  logic [AW-1:0] host_x_addr, host_y_addr, host_z_addr;
  logic [DW-1:0] host_x_din, host_y_din;
  logic          host_x_wr_en, host_y_wr_en;
  logic          eng_start, eng_done;
  logic [AW-1:0] eng_x_addr, eng_y_addr, eng_z_addr;
  logic [DW-1:0] eng_z_din;
  logic          eng_z_wr_en;
  logic [AW-1:0] x_addr, y_addr, z_addr;
  logic [DW-1:0] x_din, y_din, z_din;
  logic          x_wr_en, y_wr_en, z_wr_en;

  matmul_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MATRIX_SIZE(N), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .busy(busy),
    .done_pulse(done_pulse), .timeout(timeout), .run_cycles(run_cycles), .host_wr_err(host_wr_err),
    .host_x_addr(host_x_addr), .host_y_addr(host_y_addr), .host_z_addr(host_z_addr),
    .host_x_din(host_x_din), .host_y_din(host_y_din),
    .host_x_wr_en(host_x_wr_en), .host_y_wr_en(host_y_wr_en),
    .eng_start(eng_start), .eng_done(eng_done),
    .eng_x_addr(eng_x_addr), .eng_y_addr(eng_y_addr), .eng_z_addr(eng_z_addr),
    .eng_z_din(eng_z_din), .eng_z_wr_en(eng_z_wr_en),
    .x_addr(x_addr), .y_addr(y_addr), .z_addr(z_addr),
    .x_din(x_din), .y_din(y_din), .z_din(z_din),
    .x_wr_en(x_wr_en), .y_wr_en(y_wr_en), .z_wr_en(z_wr_en)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] x_mem [0:(1<<AW)-1];
  logic [DW-1:0] y_mem [0:(1<<AW)-1];
  logic [DW-1:0] z_mem [0:(1<<AW)-1];

  always @(posedge clock) begin
    if (x_wr_en) x_mem[x_addr] <= x_din;
    if (y_wr_en) y_mem[y_addr] <= y_din;
    if (z_wr_en) z_mem[z_addr] <= z_din;
  end

  logic [DW-1:0] ref_x [0:NN-1];
  logic [DW-1:0] ref_y [0:NN-1];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_z(input int idx);
    logic [DW-1:0] acc;
    acc = '0;
    for (int k = 0; k < N; k++)
      acc += ref_x[(idx / N) * N + k] * ref_y[k * N + (idx % N)];
    return acc;
  endfunction

  // Engine model: on start, computes the product from the BRAMs, writes Z over
  // the first NN RUN cycles, and raises done eng_delay cycles after start.
  int eng_delay = 20;
  int eng_stale = 0;
  bit eng_hang  = 1'b0;

  initial begin
    logic [DW-1:0] zbuf [0:NN-1];
    eng_done = 1'b0; eng_z_wr_en = 1'b0; eng_z_addr = '0; eng_z_din = '0;
    forever begin
      @(negedge clock);
      if (eng_start && reset) begin
        eng_done = (eng_stale > 0);
        for (int i = 0; i < NN; i++) begin
          zbuf[i] = '0;
          for (int k = 0; k < N; k++)
            zbuf[i] += x_mem[(i / N) * N + k] * y_mem[k * N + (i % N)];
        end
        for (int c = 1; reset && (eng_hang || c <= eng_delay); c++) begin
          @(negedge clock);
          eng_z_wr_en = 1'b0;
          if (c <= NN) begin
            eng_z_addr  = AW'(c - 1);
            eng_z_din   = zbuf[c - 1];
            eng_z_wr_en = 1'b1;
          end
          eng_done = ((c == eng_delay) && !eng_hang) || (c < eng_stale);
        end
        eng_z_wr_en = 1'b0;
        if (!reset) eng_done = 1'b0;
      end
    end
  end

  task automatic load_mats();
    for (int i = 0; i < NN; i++) begin
      @(negedge clock);
      host_x_addr = AW'(i); host_x_din = ref_x[i]; host_x_wr_en = 1'b1;
      host_y_addr = AW'(i); host_y_din = ref_y[i]; host_y_wr_en = 1'b1;
    end
    @(negedge clock);
    host_x_wr_en = 1'b0; host_y_wr_en = 1'b0;
  endtask

  task automatic rand_mats();
    for (int i = 0; i < NN; i++) begin
      ref_x[i] = DW'($urandom_range(0, 1000));
      ref_y[i] = DW'($urandom_range(0, 1000));
    end
  endtask

  task automatic check_z(input string tag);
    for (int i = 0; i < NN; i++)
      chk($sformatf("%s_z%0d", tag, i), z_mem[i], ref_z(i));
  endtask

  // One job from an IDLE negedge; returns at the first IDLE negedge after done.
  task automatic run_job(input string tag, input int d, input int stale,
                         input bit acc_wr, input bit col_wr);
    int done_at, start_at, n_done, ready_busy;
    logic [DW-1:0] v;
    eng_delay = d; eng_stale = stale; eng_hang = 1'b0;
    eng_x_addr  = AW'($urandom_range(512, 1023));
    eng_y_addr  = AW'($urandom_range(512, 1023));
    host_x_addr = AW'($urandom_range(16, 511));
    host_y_addr = AW'($urandom_range(16, 511));
    cmd_valid = 1'b1;
    chk({tag, "_ready_idle"}, cmd_ready, 1);
    if (acc_wr) begin
      v = $urandom;
      host_x_addr = 5; host_x_din = v; host_x_wr_en = 1'b1;
      ref_x[5] = v;
    end
    done_at = -1; start_at = -1; n_done = 0; ready_busy = 0;
    for (int k = 1; k <= d + 20; k++) begin
      @(negedge clock);
      cmd_valid = 1'b0; host_x_wr_en = 1'b0;
      if (k == 1 && acc_wr) chk({tag, "_acc_wr_err"}, host_wr_err, 0);
      if (eng_start && start_at < 0) start_at = k;
      if (done_pulse) begin
        n_done++;
        if (done_at < 0) done_at = k;
      end
      if (busy && cmd_ready) ready_busy++;
      if (k == 3) begin
        chk({tag, "_x_addr_eng"}, x_addr, eng_x_addr);
        chk({tag, "_y_addr_eng"}, y_addr, eng_y_addr);
      end
      if (col_wr && k == 10) begin
        host_x_addr = 5; host_x_din = ~ref_x[5]; host_x_wr_en = 1'b1;
        #1 chk({tag, "_col_x_wr_en"}, x_wr_en, 0);
      end
      if (col_wr && k == 11) chk({tag, "_col_err_pulse"}, host_wr_err, 1);
      if (col_wr && k == 12) chk({tag, "_col_err_end"}, host_wr_err, 0);
      if (done_at >= 0 && k == done_at + 1) break;
    end
    chk({tag, "_start_lat"}, start_at, 2);
    chk({tag, "_done_lat"}, done_at, d + 4);
    chk({tag, "_done_count"}, n_done, 1);
    chk({tag, "_ready_busy"}, ready_busy, 0);
    chk({tag, "_ready_back"}, cmd_ready, 1);
    chk({tag, "_run_cycles"}, run_cycles, d);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_x_addr_host"}, x_addr, host_x_addr);
    chk({tag, "_x5"}, x_mem[5], ref_x[5]);
    check_z(tag);
  endtask

  initial begin
    int acc, nd, rb, done_at, starts;
    reset = 1'b1; cmd_valid = 1'b0;
    host_x_addr = '0; host_y_addr = '0; host_z_addr = '0;
    host_x_din = '0; host_y_din = '0; host_x_wr_en = 1'b0; host_y_wr_en = 1'b0;
    eng_x_addr = '0; eng_y_addr = '0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_start", eng_start, 0);
    chk("rst_done", done_pulse, 0);
    chk("rst_run_cycles", run_cycles, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_wr_err", host_wr_err, 0);
    reset = 1'b1;

    // identity times two-identity
    for (int i = 0; i < NN; i++) begin
      ref_x[i] = (i / N == i % N) ? 32'd1 : 32'd0;
      ref_y[i] = (i / N == i % N) ? 32'd2 : 32'd0;
    end
    load_mats();
    run_job("ident", 100, 0, 1'b0, 1'b0);

    rand_mats();
    load_mats();
    run_job("collide", 60, 0, 1'b1, 1'b1);

    chk("stale_level", eng_done, 1);
    run_job("stale", 40, 10, 1'b0, 1'b0);

    // cmd_valid held: one accept per IDLE visit, period eng_delay+5
    eng_delay = 20; eng_stale = 0;
    cmd_valid = 1'b1; acc = 0; nd = 0; rb = 0;
    for (int k = 0; k < 75; k++) begin
      if (k > 0) @(negedge clock);
      if (cmd_ready) acc++;
      if (done_pulse) nd++;
      if (busy && cmd_ready) rb++;
    end
    @(negedge clock);
    cmd_valid = 1'b0;
    chk("held_accepts", acc, 3);
    chk("held_dones", nd, 3);
    chk("held_ready_busy", rb, 0);
    chk("held_idle", busy, 0);

    // reset in the middle of RUN
    eng_delay = 100;
    host_x_addr = AW'($urandom_range(16, 511));
    eng_x_addr  = AW'($urandom_range(512, 1023));
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (30) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_start", eng_start, 0);
    chk("midrst_done", done_pulse, 0);
    chk("midrst_run_cycles", run_cycles, 0);
    chk("midrst_wr_err", host_wr_err, 0);
    chk("midrst_owner", x_addr, host_x_addr);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    starts = 0;
    repeat (10) begin
      @(negedge clock);
      if (eng_start || busy) starts++;
    end
    chk("midrst_no_restart", starts, 0);

    // engine never finishes
    eng_hang = 1'b1; eng_stale = 0;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    done_at = -1; nd = 0;
    for (int k = 2; k <= 300; k++) begin
      @(negedge clock);
      if (done_pulse) begin
        nd++;
        if (done_at < 0) done_at = k;
      end
    end
`ifdef MATMUL_CTRL_TIMEOUT_EN
    chk("wd_done_lat", done_at, TO + 4);
    chk("wd_done_count", nd, 1);
    chk("wd_timeout", timeout, 1);
    chk("wd_run_cycles", run_cycles, TO);
    chk("wd_busy", busy, 0);
`else
    chk("hang_done_count", nd, 0);
    chk("hang_busy", busy, 1);
    chk("hang_timeout", timeout, 0);
    chk("hang_run_cycles", run_cycles, 297);
`endif
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    eng_hang = 1'b0;
    @(negedge clock);

    for (int j = 0; j < 2; j++) begin
      rand_mats();
      load_mats();
      run_job($sformatf("rand%0d", j), $urandom_range(20, 80), 0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
